ram_fifo_ctrl: RTL

- Synchronous FIFO controller that owns both ports of the team's DualPortRAM (DATA_WIDTH x 2**ADDR_WIDTH, 1-cycle registered read).
- Port A is write-only: it receives pushes from the upstream producer.
- Port B is read-only: it prefetches entries into a 2-entry output buffer, which presents show-ahead data to the downstream consumer.
- Both sides use a valid/ready handshake. Used as the buffering stage between CPU pipeline producers and consumers, e.g. the store or writeback queues.

---
 rtl/fifo_out_skid.sv | 47 ++++
 rtl/ram_fifo_ctrl.sv | 96 +++++++++
 2 files changed

// File: rtl/fifo_out_skid.sv
// Two-entry show-ahead output buffer that captures RAM read returns in FIFO order.
// The parent's issue logic guarantees a load never arrives when both slots stay occupied.
module fifo_out_skid #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] loadData_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic [1:0]            cnt_o
);

  logic [DATA_WIDTH-1:0] memQ [2];
  logic                  headQ, headD;
  logic [1:0]            cntQ, cntD;
  logic                  tailIdx;

  // With two slots the tail equals the head when empty or full, otherwise the other slot.
  assign tailIdx = headQ ^ cntQ[0];

  always_comb begin
    headD = headQ ^ pop_i;
    cntD  = cntQ + {1'b0, load_i} - {1'b0, pop_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      headQ <= 1'b0;
      cntQ  <= 2'd0;
    end else begin
      headQ <= headD;
      cntQ  <= cntD;
    end
  end

  always_ff @(posedge clk_i) begin
    if (load_i) memQ[tailIdx] <= loadData_i;
  end

  assign data_o  = memQ[headQ];
  assign valid_o = (cntQ != 2'd0);
  assign cnt_o   = cntQ;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving both ports of an external DualPortRAM: port A writes pushes,
// port B prefetches into a two-entry show-ahead buffer. Capacity is DEPTH+2 entries.
module ram_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic [DATA_WIDTH-1:0] iData,
  input  logic                  iValid,
  output logic                  oReady,
  output logic [DATA_WIDTH-1:0] oData,
  output logic                  oValid,
  input  logic                  iReady,
  output logic [ADDR_WIDTH+1:0] oLevel,
  output logic                  oRamEnA,
  output logic                  oRamWeA,
  output logic [ADDR_WIDTH-1:0] oRamAddrA,
  output logic [DATA_WIDTH-1:0] oRamDataA,
  output logic                  oRamEnB,
  output logic                  oRamWeB,
  output logic [ADDR_WIDTH-1:0] oRamAddrB,
  input  logic [DATA_WIDTH-1:0] iRamDataB
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] RAM_FULL = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wrPtrQ, wrPtrD, rdPtrQ, rdPtrD;
  logic [ADDR_WIDTH:0]   ramCntQ, ramCntD;
  logic                  rdPendQ, rdPendD;
  logic [ADDR_WIDTH+1:0] levelQ, levelD;
  logic [1:0]            obCnt;
  logic [2:0]            bufUsed;
  logic                  push, pop, issue, load;

  // A read may issue only if its return still fits after this cycle's pop.
  always_comb begin
    push    = 1'b0;
    pop     = 1'b0;
    issue   = 1'b0;
    bufUsed = {1'b0, obCnt} + {2'b0, rdPendQ};
    if (!iRst) begin
      push  = iValid && oReady;
      pop   = oValid && iReady;
      issue = (ramCntQ != '0) && (bufUsed < (3'd2 + {2'b0, pop}));
    end
    wrPtrD  = push  ? wrPtrQ + ADDR_WIDTH'(1) : wrPtrQ;
    rdPtrD  = issue ? rdPtrQ + ADDR_WIDTH'(1) : rdPtrQ;
    ramCntD = ramCntQ + (ADDR_WIDTH + 1)'(push) - (ADDR_WIDTH + 1)'(issue);
    rdPendD = issue;
    levelD  = levelQ + (ADDR_WIDTH + 2)'(push) - (ADDR_WIDTH + 2)'(pop);
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      wrPtrQ  <= '0;
      rdPtrQ  <= '0;
      ramCntQ <= '0;
      rdPendQ <= 1'b0;
      levelQ  <= '0;
    end else begin
      wrPtrQ  <= wrPtrD;
      rdPtrQ  <= rdPtrD;
      ramCntQ <= ramCntD;
      rdPendQ <= rdPendD;
      levelQ  <= levelD;
    end
  end

  assign load = rdPendQ && !iRst;

  fifo_out_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) uSkid (
    .clk_i     (iClk),
    .rst_i     (iRst),
    .load_i    (load),
    .loadData_i(iRamDataB),
    .pop_i     (pop),
    .data_o    (oData),
    .valid_o   (oValid),
    .cnt_o     (obCnt)
  );

  assign oReady    = (ramCntQ < RAM_FULL);
  assign oLevel    = levelQ;
  assign oRamEnA   = push;
  assign oRamWeA   = push;
  assign oRamAddrA = wrPtrQ;
  assign oRamDataA = iData;
  assign oRamEnB   = issue;
  assign oRamWeB   = 1'b0;
  assign oRamAddrB = rdPtrQ;

endmodule
